// File: rtl/nvdla_sdp_unpack_pkg.sv
// Shared types and elaboration helpers for the SDP width-converter family.
package nvdla_sdp_unpack_pkg;

   localparam int unsigned MAX_RATIO = 32;

   typedef enum logic {
      EMPTY = 1'b0,
      SEND  = 1'b1
   } unpack_state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   function automatic int unsigned cw_of(input int unsigned ratio);
      return (ratio <= 1) ? 1 : clog2(ratio);
   endfunction

   function automatic bit ratio_ok(input int unsigned iw, input int unsigned ow);
      return (ow != 0) && (iw % ow == 0) && (iw / ow >= 1) && (iw / ow <= MAX_RATIO);
   endfunction

endpackage

// File: rtl/nvdla_sdp_core_unpack_flex_if.sv
// Beat-in / segment-out handshake bundle for the flexible SDP unpacker.
interface nvdla_sdp_core_unpack_flex_if
   import nvdla_sdp_unpack_pkg::*;
#(
   parameter int unsigned IW = 512,
   parameter int unsigned OW = 128
);
   localparam int unsigned CW = cw_of(IW / OW);

   logic          inp_pvld;
   logic          inp_prdy;
   logic [IW-1:0] inp_data;
   logic [CW-1:0] inp_nseg;
   logic          inp_last;
   logic          out_pvld;
   logic          out_prdy;
   logic [OW-1:0] out_data;
   logic          out_last;

   modport slave (
      input  inp_pvld, inp_data, inp_nseg, inp_last, out_prdy,
      output inp_prdy, out_pvld, out_data, out_last
   );

   modport master (
      output inp_pvld, inp_data, inp_nseg, inp_last, out_prdy,
      input  inp_prdy, out_pvld, out_data, out_last
   );

endinterface

// File: rtl/nvdla_sdp_unpack_seg_mux.sv
// Selects OW-bit segment `sel` out of an IW-bit word; out-of-range sel yields zero.
module nvdla_sdp_unpack_seg_mux #(
   parameter int unsigned IW = 512,
   parameter int unsigned OW = 128,
   parameter int unsigned SW = 2
) (
   input  logic [IW-1:0] din,
   input  logic [SW-1:0] sel,
   output logic [OW-1:0] dout
);
   localparam int unsigned RATIO = IW / OW;

   always_comb begin
      dout = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (sel == SW'(k)) dout = din[k*OW +: OW];
      end
   end

endmodule

// File: rtl/nvdla_sdp_core_unpack_flex.sv
// Wide-to-narrow SDP unpacker, LSB segment first, per-beat segment count and frame-last.
// Optional macro NVDLA_SDP_UNPACK_SKID_EN adds a 1-entry input skid (registered inp_prdy).
module nvdla_sdp_core_unpack_flex
   import nvdla_sdp_unpack_pkg::*;
#(
   parameter int unsigned IW = 512,
   parameter int unsigned OW = 128
) (
   input  logic                          nvdla_core_clk,
   input  logic                          nvdla_core_rstn,
   nvdla_sdp_core_unpack_flex_if.slave   io,
   output logic                          unpack_idle
);
   localparam int unsigned   RATIO    = IW / OW;
   localparam int unsigned   CW       = cw_of(RATIO);
   localparam logic [CW-1:0] NSEG_MAX = CW'(RATIO - 1);

   generate
      if (!ratio_ok(IW, OW)) begin : g_bad_ratio
         $error("nvdla_sdp_core_unpack_flex: IW must be a multiple of OW with ratio 1..32");
      end
   endgenerate

   unpack_state_e st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] hold_data_q, hold_data_d;
   logic [CW-1:0] hold_nseg_q, hold_nseg_d;
   logic          hold_last_q, hold_last_d;

   logic          held, is_last, out_acc, load_rdy, load, in_acc, inp_rdy, skid_busy;
   logic          src_vld, src_last;
   logic [IW-1:0] src_data;
   logic [CW-1:0] src_nseg;

   assign held     = (st_q == SEND);
   assign is_last  = (cnt_q == hold_nseg_q);
   assign out_acc  = held & io.out_prdy;
   assign load_rdy = !held | (io.out_prdy & is_last);
   assign load     = src_vld & load_rdy;

`ifdef NVDLA_SDP_UNPACK_SKID_EN
   logic          skid_vld_q, skid_vld_d, skid_cap;
   logic [IW-1:0] skid_data_q;
   logic [CW-1:0] skid_nseg_q;
   logic          skid_last_q;

   // A pending skid entry always has priority over the port, keeping beat order.
   always_comb begin
      src_vld    = skid_vld_q | io.inp_pvld;
      src_data   = skid_vld_q ? skid_data_q : io.inp_data;
      src_nseg   = skid_vld_q ? skid_nseg_q : io.inp_nseg;
      src_last   = skid_vld_q ? skid_last_q : io.inp_last;
      skid_cap   = !skid_vld_q & io.inp_pvld & !load_rdy;
      skid_vld_d = skid_vld_q ? !load : skid_cap;
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) skid_vld_q <= 1'b0;
      else                  skid_vld_q <= skid_vld_d;
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (skid_cap) begin
         skid_data_q <= io.inp_data;
         skid_nseg_q <= io.inp_nseg;
         skid_last_q <= io.inp_last;
      end
   end

   assign inp_rdy   = !skid_vld_q;
   assign skid_busy = skid_vld_q;
`else
   always_comb begin
      src_vld  = io.inp_pvld;
      src_data = io.inp_data;
      src_nseg = io.inp_nseg;
      src_last = io.inp_last;
   end

   assign inp_rdy   = load_rdy;
   assign skid_busy = 1'b0;
`endif

   assign in_acc = io.inp_pvld & inp_rdy;

   // State register
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         st_q  <= EMPTY;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      hold_data_q <= hold_data_d;
      hold_nseg_q <= hold_nseg_d;
      hold_last_q <= hold_last_d;
   end

   // Next state: a load on the final segment's accept overrides the return to EMPTY.
   always_comb begin
      st_d        = st_q;
      cnt_d       = cnt_q;
      hold_data_d = hold_data_q;
      hold_nseg_d = hold_nseg_q;
      hold_last_d = hold_last_q;
      if (out_acc) begin
         if (is_last) begin
            cnt_d = '0;
            st_d  = EMPTY;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (load) begin
         st_d        = SEND;
         cnt_d       = '0;
         hold_data_d = src_data;
         hold_nseg_d = (src_nseg > NSEG_MAX) ? NSEG_MAX : src_nseg;
         hold_last_d = src_last;
      end
   end

   // Outputs
   always_comb begin
      io.out_pvld = held;
      io.out_last = held & is_last & hold_last_q;
      io.inp_prdy = inp_rdy;
      unpack_idle = !held & !io.inp_pvld & !skid_busy;
   end

   nvdla_sdp_unpack_seg_mux #(
      .IW (IW),
      .OW (OW),
      .SW (CW)
   ) u_seg_mux (
      .din  (hold_data_q),
      .sel  (cnt_q),
      .dout (io.out_data)
   );

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rstn && in_acc)
         assert (io.inp_nseg <= NSEG_MAX)
         else $error("inp_nseg %0d exceeds RATIO-1 (%0d)", io.inp_nseg, NSEG_MAX);
   end

endmodule

// File: tb/tb_nvdla_sdp_core_unpack_flex.sv
// Bench for nvdla_sdp_core_unpack_flex: directed scenarios plus random traffic vs a beat-queue model.
module tb_nvdla_sdp_core_unpack_flex;
   import nvdla_sdp_unpack_pkg::*;

   localparam int unsigned IW    = 512;
   localparam int unsigned OW    = 128;
   localparam int unsigned RATIO = IW / OW;
   localparam int unsigned CW    = cw_of(RATIO);

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic unpack_idle;
   always #5 clk = ~clk;

   nvdla_sdp_core_unpack_flex_if #(.IW(IW), .OW(OW)) u_if ();

   nvdla_sdp_core_unpack_flex #(.IW(IW), .OW(OW)) u_dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .io              (u_if.slave),
      .unpack_idle     (unpack_idle)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [IW-1:0] data;
      int unsigned   nseg;
      bit            last;
      int unsigned   idx;
   } beat_t;

   // Beats currently inside the DUT; front entry is the one being emitted.
   beat_t beats[$];

   task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OW-1:0] seg_of(input logic [IW-1:0] d, input int unsigned k);
      logic [IW-1:0] t;
      t = d >> (k * OW);
      return t[OW-1:0];
   endfunction

   function automatic logic [IW-1:0] rnd_data();
      logic [IW-1:0] r;
      for (int i = 0; i < IW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic bit exp_inp_prdy(input bit opr);
`ifdef NVDLA_SDP_UNPACK_SKID_EN
      return beats.size() < 2;
`else
      if (beats.size() == 0) return 1'b1;
      return (beats.size() == 1) && (beats[0].idx == beats[0].nseg) && opr;
`endif
   endfunction

   task automatic step(input bit pv, input logic [IW-1:0] d, input int unsigned n,
                       input bit l, input bit opr, output bit acc);
      bit    e_pvld, e_prdy;
      beat_t b;
      @(negedge clk);
      u_if.inp_pvld = pv;
      u_if.inp_data = d;
      u_if.inp_nseg = CW'(n);
      u_if.inp_last = l;
      u_if.out_prdy = opr;
      #1;
      e_pvld = beats.size() > 0;
      e_prdy = exp_inp_prdy(opr);
      chk("out_pvld", IW'(u_if.out_pvld), IW'(e_pvld));
      chk("inp_prdy", IW'(u_if.inp_prdy), IW'(e_prdy));
      chk("unpack_idle", IW'(unpack_idle), IW'(beats.size() == 0 && !pv));
      if (e_pvld) begin
         chk("out_data", IW'(u_if.out_data), IW'(seg_of(beats[0].data, beats[0].idx)));
         chk("out_last", IW'(u_if.out_last),
             IW'(beats[0].last && (beats[0].idx == beats[0].nseg)));
      end
      acc = pv && e_prdy;
      @(posedge clk);
      if (e_pvld && opr) begin
         b = beats.pop_front();
         b.idx++;
         if (b.idx <= b.nseg) beats.push_front(b);
      end
      if (acc) begin
         b.data = d; b.nseg = n; b.last = l; b.idx = 0;
         beats.push_back(b);
      end
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 64 && beats.size() > 0; i++) step(1'b0, '0, 0, 1'b0, 1'b1, acc);
   endtask

   initial begin
      bit            acc;
      logic [IW-1:0] d;
      int unsigned   n;
      bit            l, pv;

      u_if.inp_pvld = 1'b0;
      u_if.inp_data = '0;
      u_if.inp_nseg = '0;
      u_if.inp_last = 1'b0;
      u_if.out_prdy = 1'b0;
      #2;
      chk("rst_out_pvld", IW'(u_if.out_pvld), '0);
      chk("rst_out_last", IW'(u_if.out_last), '0);
      chk("rst_idle", IW'(unpack_idle), IW'(1));
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Single full beat, frame-last, free-running output.
      step(1'b1, rnd_data(), 3, 1'b1, 1'b1, acc);
      repeat (5) step(1'b0, '0, 0, 1'b0, 1'b1, acc);

      // Back-to-back beats A (nseg=1) then B (nseg=2): reload on A's last segment.
      step(1'b1, rnd_data(), 1, 1'b0, 1'b1, acc);
      d = rnd_data();
      acc = 1'b0;
      for (int i = 0; i < 8 && !acc; i++) step(1'b1, d, 2, 1'b1, 1'b1, acc);
      drain();

      // Output stalls: pattern 1,0,0,1,1,1 with a 4-segment beat.
      step(1'b1, rnd_data(), 3, 1'b0, 1'b1, acc);
      step(1'b0, '0, 0, 1'b0, 1'b1, acc);
      step(1'b0, '0, 0, 1'b0, 1'b0, acc);
      step(1'b0, '0, 0, 1'b0, 1'b0, acc);
      step(1'b0, '0, 0, 1'b0, 1'b1, acc);
      drain();

      // Streamed single-segment partial beats.
      for (int i = 0; i < 8; i++) step(1'b1, rnd_data(), 0, 1'($urandom_range(0, 1)), 1'b1, acc);
      drain();

      // Reset with segment 2 of 4 pending.
      step(1'b1, rnd_data(), 3, 1'b1, 1'b1, acc);
      step(1'b0, '0, 0, 1'b0, 1'b1, acc);
      step(1'b0, '0, 0, 1'b0, 1'b1, acc);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      beats.delete();
      chk("midrst_out_pvld", IW'(u_if.out_pvld), '0);
      chk("midrst_out_last", IW'(u_if.out_last), '0);
      chk("midrst_idle", IW'(unpack_idle), IW'(1));
      @(negedge clk);
      rstn = 1'b1;
      step(1'b1, rnd_data(), 3, 1'b1, 1'b1, acc);
      drain();

      // Random traffic; an offered beat is held until it is taken.
      pv = 1'b0; d = '0; n = 0; l = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pv) begin
            pv = ($urandom_range(0, 3) != 0);
            d  = rnd_data();
            n  = $urandom_range(0, RATIO - 1);
            l  = 1'($urandom_range(0, 1));
         end
         step(pv, d, n, l, ($urandom_range(0, 3) != 0), acc);
         if (acc) pv = 1'b0;
      end
      drain();
      step(1'b0, '0, 0, 1'b0, 1'b0, acc);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit exceeded");
   end

endmodule
